// File: rtl/node_turn_executor_pkg.sv
// node_turn_executor_pkg: shared state, turn and motor encodings plus default timing constants
package node_turn_executor_pkg;
  typedef enum logic [2:0] {IDLE, FOLLOW, NODE, SETTLE, CREEP, TURN, DONE, FAULT} state_t;
  typedef enum logic [1:0] {TURN_STRAIGHT, TURN_RIGHT, TURN_UTURN, TURN_LEFT} turn_t;
  typedef enum logic [1:0] {MOT_STOP = 2'b00, MOT_FWD = 2'b01, MOT_REV = 2'b10} mot_t;
  localparam int SETTLE_CYC_DEF       = 16;
  localparam int CREEP_CYC_DEF        = 312500;
  localparam int TURN_MIN_CYC_DEF     = 625000;
  localparam int UTURN_MIN_CYC_DEF    = 1562500;
  localparam int TURN_TIMEOUT_CYC_DEF = 4687500;
  localparam int CNT_W_DEF            = 23;
endpackage

// File: rtl/node_turn_executor_line_follow_steer.sv
// line_follow_steer: sensor-to-wheel steering with a held last command for sensor dropouts
// ports: clk_3125KHz/rst_n clock and async reset; en lets the hold register track;
//        line_l/c/r sensors; cmd_l/cmd_r wheel commands (decoded, or held when no sensor sees the line)
module line_follow_steer
  import node_turn_executor_pkg::*;
(
  input  logic       clk_3125KHz,
  input  logic       rst_n,
  input  logic       en,
  input  logic       line_l,
  input  logic       line_c,
  input  logic       line_r,
  output logic [1:0] cmd_l,
  output logic [1:0] cmd_r
);
  logic [1:0] hold_l, hold_r, dec_l, dec_r;
  logic any;
  always_comb begin
    any   = line_l | line_c | line_r;
    dec_l = (line_l & ~line_r) ? MOT_STOP : MOT_FWD;
    dec_r = (line_r & ~line_l) ? MOT_STOP : MOT_FWD;
    cmd_l = any ? dec_l : hold_l;
    cmd_r = any ? dec_r : hold_r;
  end
  always_ff @(posedge clk_3125KHz or negedge rst_n)
    if (!rst_n) begin
      hold_l <= MOT_STOP;
      hold_r <= MOT_STOP;
    end else if (en && any) begin
      hold_l <= dec_l;
      hold_r <= dec_r;
    end
endmodule

// File: rtl/node_turn_executor.sv
// node_turn_executor: line following, node arrival detection and turn execution on a differential drive
// ports: clk_3125KHz/rst_n clock and async active-low reset; run_en run/stop; node_flag node level;
//        line_l/c/r line sensors; turn_flag planner turn code; path_len nodes to traverse (0 = unbounded);
//        node_changed arrival pulse; mot_l/mot_r wheel commands; node_count accepted nodes;
//        path_done high in DONE; fault high in FAULT
module node_turn_executor
  import node_turn_executor_pkg::*;
#(
  parameter int SETTLE_CYC       = SETTLE_CYC_DEF,
  parameter int CREEP_CYC        = CREEP_CYC_DEF,
  parameter int TURN_MIN_CYC     = TURN_MIN_CYC_DEF,
  parameter int UTURN_MIN_CYC    = UTURN_MIN_CYC_DEF,
  parameter int TURN_TIMEOUT_CYC = TURN_TIMEOUT_CYC_DEF,
  parameter int CNT_W            = CNT_W_DEF
) (
  input  logic       clk_3125KHz,
  input  logic       rst_n,
  input  logic       run_en,
  input  logic       node_flag,
  input  logic       line_l,
  input  logic       line_c,
  input  logic       line_r,
  input  logic [1:0] turn_flag,
  input  logic [4:0] path_len,
  output logic       node_changed,
  output logic [1:0] mot_l,
  output logic [1:0] mot_r,
  output logic [4:0] node_count,
  output logic       path_done,
  output logic       fault
);
  state_t state, state_n;
  turn_t turn_r;
  logic [CNT_W-1:0] timer;
  logic [1:0] nf_sync, steer_l, steer_r, mot_l_n, mot_r_n;
  logic nf_prev, node_edge, settle_end, creep_end, turn_min_ok, turn_timeout;
  line_follow_steer u_steer (
    .clk_3125KHz(clk_3125KHz),
    .rst_n(rst_n),
    .en(state_n == FOLLOW),
    .line_l(line_l),
    .line_c(line_c),
    .line_r(line_r),
    .cmd_l(steer_l),
    .cmd_r(steer_r)
  );
  always_comb begin
    node_edge    = nf_sync[1] & ~nf_prev;
    settle_end   = timer == CNT_W'(SETTLE_CYC - 1);
    creep_end    = timer == CNT_W'(CREEP_CYC - 1);
    turn_min_ok  = timer >= (turn_r == TURN_UTURN ? CNT_W'(UTURN_MIN_CYC) : CNT_W'(TURN_MIN_CYC));
    turn_timeout = timer == CNT_W'(TURN_TIMEOUT_CYC - 1);
    state_n = state;
    if (!run_en) state_n = IDLE;
    else
      case (state)
        IDLE:    state_n = FOLLOW;
        FOLLOW:  state_n = node_edge ? NODE : FOLLOW;
        NODE:    state_n = SETTLE;
        SETTLE:  state_n = !settle_end ? SETTLE : (path_len != 5'd0 && node_count == path_len) ? DONE : CREEP;
        CREEP:   state_n = !creep_end ? CREEP : (turn_r == TURN_STRAIGHT) ? FOLLOW : TURN;
        TURN:    state_n = (turn_min_ok && line_c) ? FOLLOW : turn_timeout ? FAULT : TURN;
        default: state_n = state;
      endcase
    // motor commands are registered against the state being entered
    mot_l_n = state_n == FOLLOW ? steer_l : state_n == CREEP ? MOT_FWD :
              state_n == TURN ? (turn_r == TURN_RIGHT ? MOT_FWD : MOT_REV) : MOT_STOP;
    mot_r_n = state_n == FOLLOW ? steer_r : state_n == CREEP ? MOT_FWD :
              state_n == TURN ? (turn_r == TURN_RIGHT ? MOT_REV : MOT_FWD) : MOT_STOP;
  end
  always_ff @(posedge clk_3125KHz or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      turn_r       <= TURN_STRAIGHT;
      timer        <= '0;
      nf_sync      <= '0;
      nf_prev      <= 1'b0;
      node_changed <= 1'b0;
      node_count   <= '0;
      mot_l        <= MOT_STOP;
      mot_r        <= MOT_STOP;
      path_done    <= 1'b0;
      fault        <= 1'b0;
    end else begin
      nf_sync      <= {nf_sync[0], node_flag};
      nf_prev      <= nf_sync[1];
      state        <= state_n;
      timer        <= state_n != state ? '0 : &timer ? timer : timer + 1'b1;
      node_changed <= state == FOLLOW && state_n == NODE;
      node_count   <= state == IDLE ? '0 :
                      (state == FOLLOW && state_n == NODE && !(&node_count)) ? node_count + 5'd1 : node_count;
      if (state == SETTLE && settle_end) turn_r <= turn_t'(turn_flag);
      mot_l        <= mot_l_n;
      mot_r        <= mot_r_n;
      path_done    <= state_n == DONE;
      fault        <= state_n == FAULT;
    end
endmodule

// File: tb/tb_node_turn_executor.sv
// tb_node_turn_executor: directed scoreboard bench for node_turn_executor
module tb_node_turn_executor;
  typedef struct {
    int kind;
    int cyc;
    int cnt;
    logic [3:0] mot;
  } ev_t;
  logic clk_3125KHz = 0, rst_n, run_en, node_flag, line_l, line_c, line_r;
  logic [1:0] turn_flag, mot_l, mot_r;
  logic [4:0] path_len, node_count;
  logic node_changed, path_done, fault;
  int total = 0, bad = 0, cyc = 0, t0, k;
  logic pd_q = 0, f_q = 0;
  ev_t q[$];
  ev_t e;
  node_turn_executor #(
    .SETTLE_CYC(4),
    .CREEP_CYC(8),
    .TURN_MIN_CYC(20),
    .UTURN_MIN_CYC(50),
    .TURN_TIMEOUT_CYC(100),
    .CNT_W(23)
  ) dut (
    .clk_3125KHz(clk_3125KHz),
    .rst_n(rst_n),
    .run_en(run_en),
    .node_flag(node_flag),
    .line_l(line_l),
    .line_c(line_c),
    .line_r(line_r),
    .turn_flag(turn_flag),
    .path_len(path_len),
    .node_changed(node_changed),
    .mot_l(mot_l),
    .mot_r(mot_r),
    .node_count(node_count),
    .path_done(path_done),
    .fault(fault)
  );
  always #5 clk_3125KHz = ~clk_3125KHz;
  always @(posedge clk_3125KHz) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic push(input int kind, input int at, input int cnt);
    ev_t n;
    n.kind = kind;
    n.cyc  = at;
    n.cnt  = cnt;
    n.mot  = 4'b0000;
    q.push_back(n);
  endtask
  task automatic to_cyc(input int t);
    while (cyc < t) @(negedge clk_3125KHz);
  endtask
  // monitor: kind 0 = node pulse, 1 = path_done rise, 2 = fault rise
  always @(negedge clk_3125KHz) begin
    if (rst_n) begin
      k = node_changed ? 0 : (path_done && !pd_q) ? 1 : (fault && !f_q) ? 2 : -1;
      if (k >= 0) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: got kind %0d at cyc %0d, want none", k, cyc);
        end else begin
          e = q.pop_front();
          chk("ev_kind", k, e.kind);
          chk("ev_cyc", cyc, e.cyc);
          chk("ev_count", int'(node_count), e.cnt);
          chk("ev_mot", int'({mot_l, mot_r}), int'(e.mot));
        end
      end
    end
    pd_q = path_done;
    f_q  = fault;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 0; run_en = 0; node_flag = 0; line_l = 0; line_c = 0; line_r = 0;
    turn_flag = 0; path_len = 0;
    repeat (3) @(negedge clk_3125KHz);
    chk("rst_mot", int'({mot_l, mot_r}), 0);
    chk("rst_count", int'(node_count), 0);
    chk("rst_pulse", int'(node_changed), 0);
    chk("rst_done", int'(path_done), 0);
    chk("rst_fault", int'(fault), 0);
    rst_n = 1;
    @(negedge clk_3125KHz);
    run_en = 1; line_l = 1;
    repeat (2) @(negedge clk_3125KHz);
    chk("steer_left", int'({mot_l, mot_r}), 4'b0001);
    line_l = 0;
    repeat (2) @(negedge clk_3125KHz);
    chk("steer_hold", int'({mot_l, mot_r}), 4'b0001);
    line_r = 1;
    repeat (2) @(negedge clk_3125KHz);
    chk("steer_right", int'({mot_l, mot_r}), 4'b0100);
    line_r = 0; line_c = 1;
    repeat (2) @(negedge clk_3125KHz);
    chk("steer_centre", int'({mot_l, mot_r}), 4'b0101);
    line_c = 0; line_l = 1;
    repeat (2) @(negedge clk_3125KHz);
    t0 = cyc; node_flag = 1; push(0, t0 + 3, 1);
    to_cyc(t0 + 5);  chk("settle_mot", int'({mot_l, mot_r}), 4'b0000);
    to_cyc(t0 + 15); chk("creep_mot", int'({mot_l, mot_r}), 4'b0101);
    to_cyc(t0 + 16); chk("back_follow", int'({mot_l, mot_r}), 4'b0001);
    to_cyc(t0 + 30); node_flag = 0;
    chk("count_1", int'(node_count), 1);
    repeat (3) @(negedge clk_3125KHz);
    turn_flag = 1; t0 = cyc; node_flag = 1; push(0, t0 + 3, 2);
    to_cyc(t0 + 5);  node_flag = 0;
    to_cyc(t0 + 15); chk("creep_right", int'({mot_l, mot_r}), 4'b0101);
    to_cyc(t0 + 16); chk("turn_right", int'({mot_l, mot_r}), 4'b0110);
    to_cyc(t0 + 26); line_l = 0; line_c = 1;
    to_cyc(t0 + 27); line_c = 0;
    chk("early_line_ignored", int'({mot_l, mot_r}), 4'b0110);
    to_cyc(t0 + 41); line_c = 1;
    chk("still_turning", int'({mot_l, mot_r}), 4'b0110);
    to_cyc(t0 + 42); chk("turn_exit", int'({mot_l, mot_r}), 4'b0101);
    line_c = 0;
    repeat (2) @(negedge clk_3125KHz);
    turn_flag = 2; t0 = cyc; node_flag = 1; push(0, t0 + 3, 3); push(2, t0 + 116, 3);
    to_cyc(t0 + 5);   node_flag = 0;
    to_cyc(t0 + 16);  chk("uturn_mot", int'({mot_l, mot_r}), 4'b1001);
    to_cyc(t0 + 115); chk("no_fault_yet", int'(fault), 0);
    to_cyc(t0 + 118); chk("fault_held", int'(fault), 1);
    chk("fault_mot", int'({mot_l, mot_r}), 4'b0000);
    run_en = 0;
    @(negedge clk_3125KHz);
    chk("fault_cleared", int'(fault), 0);
    @(negedge clk_3125KHz);
    chk("idle_count", int'(node_count), 0);
    path_len = 2; turn_flag = 0; line_c = 1; run_en = 1;
    @(negedge clk_3125KHz);
    t0 = cyc; node_flag = 1; push(0, t0 + 3, 1);
    to_cyc(t0 + 5);  node_flag = 0;
    to_cyc(t0 + 22);
    t0 = cyc; node_flag = 1; push(0, t0 + 3, 2); push(1, t0 + 8, 2);
    to_cyc(t0 + 5);  node_flag = 0;
    to_cyc(t0 + 12); chk("done_mot", int'({mot_l, mot_r}), 4'b0000);
    chk("done_flag", int'(path_done), 1);
    to_cyc(t0 + 20); chk("done_stays", int'({mot_l, mot_r}), 4'b0000);
    run_en = 0;
    @(negedge clk_3125KHz);
    chk("done_cleared", int'(path_done), 0);
    @(negedge clk_3125KHz);
    path_len = 0; turn_flag = 3; line_c = 0; run_en = 1;
    @(negedge clk_3125KHz);
    t0 = cyc; node_flag = 1; push(0, t0 + 3, 1);
    to_cyc(t0 + 5);  node_flag = 0;
    to_cyc(t0 + 20); chk("turn_left", int'({mot_l, mot_r}), 4'b1001);
    #2 rst_n = 0;
    #1 chk("async_stop", int'({mot_l, mot_r}), 4'b0000);
    chk("async_count", int'(node_count), 0);
    run_en = 0;
    @(negedge clk_3125KHz);
    rst_n = 1;
    repeat (2) @(negedge clk_3125KHz);
    chk("post_rst_mot", int'({mot_l, mot_r}), 4'b0000);
    chk("post_rst_count", int'(node_count), 0);
    chk("post_rst_pulse", int'(node_changed), 0);
    chk("pending_events", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
